// File: rtl/bayer_pkg.sv
// -----------------------------------------------------------------------------
// bayer_pkg
// Shared types for the Bayer demosaic front end.
//   PIXEL_W      : width of one sensor pixel after white balance
//   pixel_t      : one white-balanced pixel
//   scan_state_t : raster-scan sequencer states
// -----------------------------------------------------------------------------
package bayer_pkg;

    localparam int PIXEL_W = 8;

    typedef logic [PIXEL_W-1:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } scan_state_t;

endpackage

// File: rtl/rggb.sv
// -----------------------------------------------------------------------------
// rggb
// Reorders one 2x2 CFA window into a fixed {R,G1,G2,B} word, given the
// row/col parity of the window's top-left pixel.
// Ports:
//   row, col   in  1         parity selects (row = y parity, col = x parity)
//   tl,tr,bl,br in PIXEL_W   window pixels: top-left, top-right, bottom-left,
//                            bottom-right
//   word       out 4*PIXEL_W {R,G1,G2,B}, R in the top byte
// -----------------------------------------------------------------------------
module rggb
    import bayer_pkg::*;
(
    input  logic                 row,
    input  logic                 col,
    input  pixel_t               tl,
    input  pixel_t               tr,
    input  pixel_t               bl,
    input  pixel_t               br,
    output logic [4*PIXEL_W-1:0] word
);

    // R sits at (row,col) inside the window and B diagonally opposite it.
    // G1 is always taken from the top row and G2 from the bottom row, so the
    // greens keep the vertical order the colour-conversion stage expects.
    always_comb begin
        word = {tl, tr, bl, br};
        unique case ({row, col})
            2'b00: word = {tl, tr, bl, br};
            2'b01: word = {tr, tl, br, bl};
            2'b10: word = {bl, tl, br, tr};
            2'b11: word = {br, tr, bl, tl};
            default: word = {tl, tr, bl, br};
        endcase
    end

endmodule

// File: rtl/bayer_scan_ctrl.sv
// -----------------------------------------------------------------------------
// bayer_scan_ctrl
// Raster-scan sequencer for the Bayer demosaic mux. Walks a 2x2 window over a
// WIDTH x HEIGHT frame, accepts white-balanced windows over valid/ready and
// registers the reordered {R,G1,G2,B} word into a one-entry output stage.
// Ports:
//   clk, rst        clock (rising edge) and asynchronous active-high reset
//   start           pulse, begins a frame when idle
//   abort           drops the current frame and clears the output stage
//   in_valid/in_ready  window handshake from the white-balance stage
//   wb_1..wb_4      window pixels (TL, TR, BL, BR)
//   out_valid/out_ready output handshake towards colour conversion
//   out_rggb        {R,G1,G2,B}, R in [31:24]
//   out_x, out_y    window coordinates of the registered word
//   busy            sequencer is not idle
//   frame_done      one-cycle pulse after the last window has been consumed
// -----------------------------------------------------------------------------
module bayer_scan_ctrl
    import bayer_pkg::*;
#(
    parameter int WIDTH     = 640,
    parameter int HEIGHT    = 480,
    parameter int PHASE_ROW = 0,
    parameter int PHASE_COL = 0,
    parameter int XW        = $clog2(WIDTH),
    parameter int YW        = $clog2(HEIGHT)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  pixel_t               wb_1,
    input  pixel_t               wb_2,
    input  pixel_t               wb_3,
    input  pixel_t               wb_4,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*PIXEL_W-1:0] out_rggb,
    output logic [XW-1:0]        out_x,
    output logic [YW-1:0]        out_y,
    output logic                 busy,
    output logic                 frame_done
);

    localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 2);
    localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 2);

    scan_state_t          state;
    scan_state_t          next_state;
    logic [XW-1:0]        x;
    logic [YW-1:0]        y;
    logic                 accept;
    logic                 out_free;
    logic                 last_window;
    logic                 row_sel;
    logic                 col_sel;
    logic [4*PIXEL_W-1:0] mux_word;

    // The mux phase follows the live counters so the word registered on an
    // accept matches the window being accepted in that same cycle.
    assign row_sel     = y[0] ^ PHASE_ROW[0];
    assign col_sel     = x[0] ^ PHASE_COL[0];
    assign last_window = (x == X_LAST) && (y == Y_LAST);
    assign busy        = (state != IDLE);

    rggb u_rggb (
        .row  (row_sel),
        .col  (col_sel),
        .tl   (wb_1),
        .tr   (wb_2),
        .bl   (wb_3),
        .br   (wb_4),
        .word (mux_word)
    );

    // Next-state and handshake decode. The output slot is free when it is
    // empty or being drained this cycle, which gives one window per clock
    // when downstream never stalls. in_ready is dropped while abort is high
    // so upstream never sees a handshake the controller then discards.
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        accept     = 1'b0;
        out_free   = !out_valid || out_ready;
        unique case (state)
            IDLE: begin
                if (start) next_state = RUN;
            end
            RUN: begin
                in_ready = out_free;
                accept   = in_valid && out_free;
                if (accept && last_window) next_state = FLUSH;
            end
            FLUSH: begin
                if (out_free) next_state = DONE;
            end
            DONE: begin
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
        if (abort) begin
            next_state = IDLE;
            in_ready   = 1'b0;
            accept     = 1'b0;
        end
    end

    // State, window counters and the one-entry output stage. The counters
    // stay on the last window after it is accepted; the next start clears
    // them. frame_done is registered on the FLUSH->DONE step so it is high
    // exactly while the sequencer sits in DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            x          <= '0;
            y          <= '0;
            out_valid  <= 1'b0;
            out_rggb   <= '0;
            out_x      <= '0;
            out_y      <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= next_state;
            frame_done <= (state == FLUSH) && (next_state == DONE);
            if (abort) begin
                x         <= '0;
                y         <= '0;
                out_valid <= 1'b0;
                out_rggb  <= '0;
                out_x     <= '0;
                out_y     <= '0;
            end else begin
                if (state == IDLE && start) begin
                    x <= '0;
                    y <= '0;
                end
                if (accept) begin
                    out_rggb  <= mux_word;
                    out_x     <= x;
                    out_y     <= y;
                    out_valid <= 1'b1;
                    if (!last_window) begin
                        if (x == X_LAST) begin
                            x <= '0;
                            y <= y + YW'(1);
                        end else begin
                            x <= x + XW'(1);
                        end
                    end
                end else if (out_valid && out_ready) begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_bayer_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bayer_scan_ctrl
// Directed bench for bayer_scan_ctrl on a 4x3 frame (six 2x2 windows).
// -----------------------------------------------------------------------------
module tb_bayer_scan_ctrl;
    import bayer_pkg::*;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int XW = $clog2(W);
    localparam int YW = $clog2(H);

    typedef struct {
        pixel_t      tl;
        pixel_t      tr;
        pixel_t      bl;
        pixel_t      br;
        logic [31:0] rggb;
        int          x;
        int          y;
    } vec_t;

    logic          clk;
    logic          rst;
    logic          start;
    logic          abort;
    logic          in_valid;
    logic          in_ready;
    pixel_t        wb_1;
    pixel_t        wb_2;
    pixel_t        wb_3;
    pixel_t        wb_4;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_rggb;
    logic [XW-1:0] out_x;
    logic [YW-1:0] out_y;
    logic          busy;
    logic          frame_done;

    vec_t vec [6];
    int   testsRun;
    int   testsFailed;

    bayer_scan_ctrl #(
        .WIDTH     (W),
        .HEIGHT    (H),
        .PHASE_ROW (0),
        .PHASE_COL (0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .wb_1       (wb_1),
        .wb_2       (wb_2),
        .wb_3       (wb_3),
        .wb_4       (wb_4),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_rggb   (out_rggb),
        .out_x      (out_x),
        .out_y      (out_y),
        .busy       (busy),
        .frame_done (frame_done)
    );

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive every DUT input in one place.
    task automatic applyStimulus(input logic st, input logic ab, input logic iv,
                                 input logic ordy, input vec_t v);
        start     = st;
        abort     = ab;
        in_valid  = iv;
        out_ready = ordy;
        wb_1      = v.tl;
        wb_2      = v.tr;
        wb_3      = v.bl;
        wb_4      = v.br;
    endtask

    // One comparison against a bench-computed value.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Check the registered word against a table entry.
    task automatic checkWord(input string tag, input vec_t v);
        checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
        checkOutput({tag, "_rggb"}, out_rggb, v.rggb);
        checkOutput({tag, "_x"}, 32'(out_x), 32'(v.x));
        checkOutput({tag, "_y"}, 32'(out_y), 32'(v.y));
    endtask

    // Pulse start for one cycle from IDLE.
    task automatic startFrame(input vec_t idle);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, idle);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, idle);
    endtask

    initial begin
        vec_t zero;
        int   idx;
        int   pulses;

        testsRun    = 0;
        testsFailed = 0;
        zero        = '{8'h00, 8'h00, 8'h00, 8'h00, 32'h0, 0, 0};

        // Windows in raster order. Phase (row,col) = (y[0], x[0]).
        vec[0] = '{8'h11, 8'h22, 8'h33, 8'h44, 32'h11223344, 0, 0};
        vec[1] = '{8'h11, 8'h22, 8'h33, 8'h44, 32'h22114433, 1, 0};
        vec[2] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 32'hA1A2A3A4, 2, 0};
        vec[3] = '{8'h55, 8'h66, 8'h77, 8'h55, 32'h77555566, 0, 1};
        vec[4] = '{8'h11, 8'h22, 8'h33, 8'h44, 32'h44223311, 1, 1};
        vec[5] = '{8'h5A, 8'h3C, 8'hC3, 8'h5A, 32'hC35A5A3C, 2, 1};

        // Reset values.
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, zero);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
        checkOutput("rst_frame_done", 32'(frame_done), 32'd0);
        checkOutput("rst_rggb", out_rggb, 32'd0);
        rst = 1'b0;
        stepCycle();

        // in_valid in IDLE is not accepted.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, vec[0]);
        #1;
        checkOutput("idle_in_ready", 32'(in_ready), 32'd0);
        stepCycle();
        checkOutput("idle_no_accept", 32'(out_valid), 32'd0);

        // Full frame at full throughput, table driven.
        startFrame(zero);
        checkOutput("run_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, vec[i]);
            #1;
            checkOutput($sformatf("frame%0d_in_ready", i), 32'(in_ready), 32'd1);
            stepCycle();
            checkWord($sformatf("frame%0d", i), vec[i]);
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, vec[0]);
        #1;
        checkOutput("flush_in_ready", 32'(in_ready), 32'd0);
        checkOutput("flush_busy", 32'(busy), 32'd1);
        checkOutput("flush_done_low", 32'(frame_done), 32'd0);
        stepCycle();
        checkOutput("done_pulse", 32'(frame_done), 32'd1);
        checkOutput("done_drained", 32'(out_valid), 32'd0);
        stepCycle();
        checkOutput("done_cleared", 32'(frame_done), 32'd0);
        checkOutput("done_idle", 32'(busy), 32'd0);

        // Backpressure: the word holds while downstream stalls.
        startFrame(zero);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, vec[0]);
        stepCycle();
        checkWord("bp_first", vec[0]);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, vec[1]);
        for (int i = 0; i < 2; i++) begin
            #1;
            checkOutput("bp_in_ready_low", 32'(in_ready), 32'd0);
            stepCycle();
            checkWord("bp_hold", vec[0]);
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, vec[1]);
        #1;
        checkOutput("bp_in_ready_high", 32'(in_ready), 32'd1);
        stepCycle();
        checkWord("bp_release", vec[1]);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, vec[2]);
        stepCycle();
        checkWord("bp_third", vec[2]);

        // Abort after the third window: back to IDLE, no frame_done.
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, vec[3]);
        #1;
        checkOutput("abort_in_ready", 32'(in_ready), 32'd0);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, vec[3]);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_out_valid", 32'(out_valid), 32'd0);
        checkOutput("abort_no_done", 32'(frame_done), 32'd0);
        stepCycle();
        checkOutput("abort_still_idle", 32'(busy), 32'd0);
        checkOutput("abort_no_done2", 32'(frame_done), 32'd0);

        // start together with abort in IDLE: abort wins.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, zero);
        stepCycle();
        checkOutput("start_abort_idle", 32'(busy), 32'd0);

        // Restart begins again at window (0,0).
        startFrame(zero);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, vec[0]);
        stepCycle();
        checkWord("restart", vec[0]);

        // Rest of the frame with in_valid bubbles and start held high.
        idx = 1;
        for (int k = 0; k < 40 && idx < 6; k++) begin
            logic vld;
            vld = k[0];
            applyStimulus(1'b1, 1'b0, vld, 1'b1, vec[idx]);
            #1;
            checkOutput($sformatf("bub%0d_in_ready", k), 32'(in_ready), 32'd1);
            stepCycle();
            if (vld) begin
                checkWord($sformatf("bub_w%0d", idx), vec[idx]);
                idx++;
            end else begin
                checkOutput($sformatf("bub%0d_drained", k), 32'(out_valid), 32'd0);
            end
        end
        checkOutput("bub_windows", 32'(idx), 32'd6);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, zero);
        pulses = 0;
        for (int k = 0; k < 5; k++) begin
            if (frame_done) pulses++;
            stepCycle();
        end
        checkOutput("bub_done_pulses", 32'(pulses), 32'd1);
        checkOutput("bub_idle", 32'(busy), 32'd0);

        // Asynchronous reset mid-frame takes effect without a clock edge.
        startFrame(zero);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, vec[0]);
        stepCycle();
        checkWord("pre_rst", vec[0]);
        rst = 1'b1;
        #1;
        checkOutput("async_rst_valid", 32'(out_valid), 32'd0);
        checkOutput("async_rst_busy", 32'(busy), 32'd0);
        checkOutput("async_rst_in_ready", 32'(in_ready), 32'd0);
        checkOutput("async_rst_x", 32'(out_x), 32'd0);
        stepCycle();
        rst = 1'b0;
        stepCycle();
        checkOutput("post_rst_idle", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
